imem_loader: RTL and testbench

// - Byte-stream writer for the instruction memory that top_n_clic fetches from.
// - Receives a framed program image from a UART RX byte source over valid/ready.
// - Packs bytes little-endian into 32-bit words and writes them to the imem write port.
// - Holds the core in reset until a complete, valid image has been written.

---
 rtl/imem_loader.sv | 178 +++++++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a valid/ready byte stream,
// packs it little-endian into 32-bit words, writes them to the instruction
// memory and holds the core in reset until a complete, valid image is loaded.
// Frame: 0xA5, LEN_LO, LEN_HI, LEN*4 data bytes, optional XOR checksum byte.
// Optional feature macro: LOADER_CSUM_EN (trailing checksum byte required).
module imem_loader #(
  parameter int unsigned IMemSize  = 'h1000,
  parameter int unsigned AddrWidth = $clog2(IMemSize)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 imem_we,
  output logic [AddrWidth-1:0] imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 core_reset,
  output logic                 done,
  output logic                 error
);

  // word index: AddrWidth-2 bits of word address plus one guard bit
  localparam int unsigned WiW      = AddrWidth - 1;
  localparam logic [15:0] MaxWords = 16'(IMemSize >> 2);
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_e;

`ifdef LOADER_CSUM_EN
  localparam state_e AfterData = S_CSUM;
`else
  localparam state_e AfterData = S_DONE;
`endif

  state_e               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [WiW-1:0]       widx_q, widx_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [23:0]          word_q, word_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 core_reset_q, core_reset_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 accept;
  logic [15:0]          len_new;
`ifdef LOADER_CSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  // Data-byte acceptance is stalled only during the imem write cycle
  always_comb begin
    rx_ready = !((state_q == S_DATA) && we_q);
  end

  // Next-state logic: framing FSM, word packing and registered status outputs
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    accept  = rx_valid && rx_ready;
    len_new = {rx_data, len_q[7:0]};

    case (state_q)
      S_IDLE: if (accept && rx_data == SyncByte) state_d = S_LEN0;
      S_LEN0: if (accept) begin
        len_d[7:0] = rx_data;
        widx_d     = '0;
        bcnt_d     = '0;
`ifdef LOADER_CSUM_EN
        csum_d     = '0;
`endif
        state_d    = S_LEN1;
      end
      S_LEN1: if (accept) begin
        len_d = len_new;
        if (len_new > MaxWords)   state_d = S_ERR;
        else if (len_new == '0)   state_d = AfterData;
        else                      state_d = S_DATA;
      end
      // the FSM stays in DATA through the write cycle so the index bump and the
      // end-of-image decision happen together, after the write is issued
      S_DATA: begin
        if (we_q) begin
          widx_d = widx_q + 1'b1;
          if (16'(widx_q) + 16'd1 == len_q) state_d = AfterData;
        end else if (accept) begin
`ifdef LOADER_CSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              wdata_d = {rx_data, word_q};
              addr_d  = {widx_q[AddrWidth-3:0], 2'b00};
              we_d    = 1'b1;
            end
          endcase
        end
      end
`ifdef LOADER_CSUM_EN
      S_CSUM: if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (accept && rx_data == SyncByte) state_d = S_LEN0;
      default: state_d = S_IDLE;
    endcase

    core_reset_d = (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
  end

  // State registers with synchronous reset; reset also drops any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      widx_q       <= '0;
      bcnt_q       <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      widx_q       <= widx_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames, expected imem writes queued by
// the stimulus and checked by an independent write monitor.
module tb_imem_loader;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          done;
  logic          error;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];

  imem_loader #(.IMemSize('h1000)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: rx_ready must drop exactly during write cycles; each write is
  // compared against the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (rx_ready !== ~imem_we) begin
        failures++;
        $display("FAIL rx_ready: got %b expected %b (imem_we=%b)", rx_ready, ~imem_we, imem_we);
      end
    end
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_addr.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr %0h data %0h, required no write", imem_addr, imem_wdata);
      end else begin
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (imem_addr !== ea || imem_wdata !== ed) begin
          failures++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   imem_addr, imem_wdata, ea, ed);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: byte %0h not accepted, required rx_ready", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  // Completes a frame after its last data byte and checks the release
  task automatic finish_frame(input logic [7:0] csum, input string name);
`ifdef LOADER_CSUM_EN
    send_byte(csum, 0);
`else
    if (csum == 8'h00) begin end
    @(negedge clk);
`endif
    chk({name, "_done"}, done, 1);
    chk({name, "_core_reset"}, core_reset, 0);
    chk({name, "_error"}, error, 0);
  endtask

  logic [7:0]  cs;
  logic [31:0] w;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // single word, then release; garbage before sync is discarded
    send_byte(8'h3C, 0);
    chk("idle_garbage_core_reset", core_reset, 1);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    push_word(12'h000, 32'h00100513);
    send_word(32'h00100513, 0);
    finish_frame(8'h06, "one_word");

    // reload from DONE, two words with idle gaps
    send_byte(8'hA5, 0);
    chk("reload_core_reset", core_reset, 1);
    chk("reload_done", done, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    push_word(12'h000, 32'h12345678);
    push_word(12'h004, 32'hDEADBEEF);
    send_word(32'h12345678, 5);
    send_word(32'hDEADBEEF, 5);
    finish_frame(8'h2A, "two_word");

    // oversize length 0x0401 -> error, no writes
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h04, 0);
    chk("oversize_error", error, 1);
    chk("oversize_core_reset", core_reset, 1);
    chk("oversize_done", done, 0);
    send_byte(8'h55, 0);
    chk("err_garbage_error", error, 1);
    send_byte(8'hA5, 0);
    chk("err_sync_clears", error, 0);

    // LEN == 0 from the restarted frame
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef LOADER_CSUM_EN
    send_byte(8'h00, 0);
`endif
    chk("len0_done", done, 1);
    chk("len0_core_reset", core_reset, 0);

`ifdef LOADER_CSUM_EN
    // bad checksum
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    push_word(12'h000, 32'h44332211);
    send_word(32'h44332211, 0);
    send_byte(8'h00, 0);
    chk("badcsum_error", error, 1);
    chk("badcsum_done", done, 0);
    chk("badcsum_core_reset", core_reset, 1);
`endif

    // mid-frame reset after two data bytes
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_imem_we", imem_we, 0);
    chk("midrst_rx_ready", rx_ready, 1);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_wdata", imem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);
    // stale partial word must not complete: a fresh one-word frame writes only its own word
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    push_word(12'h000, 32'hCAFEF00D);
    send_word(32'hCAFEF00D, 0);
    finish_frame(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D, "post_reset");

    // full memory: LEN = 0x400, last address 0xFFC
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    cs = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      w = {8'h5A, 8'(i >> 8), 8'(i), 8'hC3};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      push_word(12'(i * 4), w);
      send_word(w, 0);
    end
    finish_frame(cs, "full");

    repeat (3) @(negedge clk);
    chk("pending_writes", exp_addr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
